// File: rtl/tp_synd_gen_t3_seq.sv
// ---------------------------------------------------------------------------
// tp_synd_gen_t3_seq
// Chase test-pattern syndrome generator for the t=3 BCH soft decoder over
// GF(2^10) (primitive polynomial x^10 + x^3 + 1).
//
// From the hard-decision syndromes S1/S3/S5 and the locators of the
// least-reliable positions, one syndrome triple per test pattern is emitted
// in Gray-code order. Each step flips exactly one LRP, so the update is a
// single XOR with that LRP's precomputed power triple {p, p^3, p^5}.
//
// Ports
//   clk            clock
//   in_ctr_Srst    synchronous active-high reset (wins over enable)
//   in_ctr_en      global enable; low freezes every register
//   in_start       start pulse; samples syndromes and locators in IDLE
//   in_synd1/3/5   hard-decision syndromes
//   in_loc         LRP locators, LRP i at [i*GF_LEN +: GF_LEN]
//   out_synd1/3/5  syndrome triple of the current test pattern
//   out_valid      output triple valid
//   out_tp_idx     Gray-coded flip mask of the current pattern
//   out_sh_en      shift enable for the downstream buffer (= out_valid)
//   out_pass_last  high on the final pattern
//   out_busy       high while preparing powers or emitting patterns
// ---------------------------------------------------------------------------
module tp_synd_gen_t3_seq #(
    parameter int GF_LEN           = 10,
    parameter int NUM_LRP          = 3,
    parameter int TEST_PATTEN_NUMS = 8
) (
    input  logic                      clk,
    input  logic                      in_ctr_Srst,
    input  logic                      in_ctr_en,
    input  logic                      in_start,
    input  logic [GF_LEN-1:0]         in_synd1,
    input  logic [GF_LEN-1:0]         in_synd3,
    input  logic [GF_LEN-1:0]         in_synd5,
    input  logic [NUM_LRP*GF_LEN-1:0] in_loc,
    output logic [GF_LEN-1:0]         out_synd1,
    output logic [GF_LEN-1:0]         out_synd3,
    output logic [GF_LEN-1:0]         out_synd5,
    output logic                      out_valid,
    output logic [NUM_LRP-1:0]        out_tp_idx,
    output logic                      out_sh_en,
    output logic                      out_pass_last,
    output logic                      out_busy
);

    localparam int                  LRP_W    = (NUM_LRP > 1) ? $clog2(NUM_LRP) : 1;
    localparam logic [GF_LEN-1:0]   POLY_LOW = GF_LEN'(9);   // x^3 + 1
    localparam logic [NUM_LRP-1:0]  LAST_K   = NUM_LRP'(TEST_PATTEN_NUMS - 1);
    localparam logic [LRP_W-1:0]    LAST_LRP = LRP_W'(NUM_LRP - 1);

    if (TEST_PATTEN_NUMS != (1 << NUM_LRP)) begin : g_bad_cfg
        $error("TEST_PATTEN_NUMS must equal 2**NUM_LRP");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        EMIT = 2'd2
    } state_t;

    typedef struct packed {
        logic [GF_LEN-1:0] p;
        logic [GF_LEN-1:0] p3;
        logic [GF_LEN-1:0] p5;
    } pw_t;

    // MSB-first shift-and-add multiply with reduction by x^10 = x^3 + 1.
    function automatic logic [GF_LEN-1:0] gf_mul(input logic [GF_LEN-1:0] a,
                                                  input logic [GF_LEN-1:0] b);
        logic [GF_LEN-1:0] r;
        r = '0;
        for (int i = GF_LEN - 1; i >= 0; i--) begin
            r = {r[GF_LEN-2:0], 1'b0} ^ (r[GF_LEN-1] ? POLY_LOW : '0);
            if (b[i]) r = r ^ a;
        end
        return r;
    endfunction

    // Index of the lowest set bit; selects which LRP a Gray step flips.
    function automatic logic [LRP_W-1:0] lsb_idx(input logic [NUM_LRP-1:0] v);
        logic [LRP_W-1:0] idx;
        idx = '0;
        for (int i = NUM_LRP - 1; i >= 0; i--) begin
            if (v[i]) idx = LRP_W'(i);
        end
        return idx;
    endfunction

    state_t             state_q;
    logic [LRP_W-1:0]   cnt_q;
    logic [NUM_LRP-1:0] k_q;
    logic [GF_LEN-1:0]  base1_q, base3_q, base5_q;
    logic [GF_LEN-1:0]  loc_q [NUM_LRP];
    pw_t                pw_q  [NUM_LRP];
    logic [GF_LEN-1:0]  synd1_q, synd3_q, synd5_q;
    logic [NUM_LRP-1:0] tp_idx_q;
    logic               valid_q, last_q, busy_q;

    // One set of multipliers shared across the PREP cycles.
    logic [GF_LEN-1:0]  p_d, p2_d, p3_d, p5_d;
    logic [NUM_LRP-1:0] k_d;
    logic [LRP_W-1:0]   b_d;
    pw_t                flip_d;

    assign p_d    = loc_q[cnt_q];
    assign p2_d   = gf_mul(p_d, p_d);
    assign p3_d   = gf_mul(p2_d, p_d);
    assign p5_d   = gf_mul(p3_d, p2_d);
    assign k_d    = k_q + NUM_LRP'(1);
    assign b_d    = lsb_idx(k_d);
    assign flip_d = pw_q[b_d];

    always_ff @(posedge clk) begin
        if (in_ctr_Srst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            k_q      <= '0;
            base1_q  <= '0;
            base3_q  <= '0;
            base5_q  <= '0;
            for (int i = 0; i < NUM_LRP; i++) begin
                loc_q[i] <= '0;
                pw_q[i]  <= '0;
            end
            synd1_q  <= '0;
            synd3_q  <= '0;
            synd5_q  <= '0;
            tp_idx_q <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else if (in_ctr_en) begin
            case (state_q)
                IDLE: begin
                    if (in_start) begin
                        base1_q <= in_synd1;
                        base3_q <= in_synd3;
                        base5_q <= in_synd5;
                        for (int i = 0; i < NUM_LRP; i++) begin
                            loc_q[i] <= in_loc[i*GF_LEN +: GF_LEN];
                        end
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= PREP;
                    end
                end
                PREP: begin
                    pw_q[cnt_q] <= '{p: p_d, p3: p3_d, p5: p5_d};
                    if (cnt_q == LAST_LRP) begin
                        // Pattern 0 is the unmodified hard-decision syndrome.
                        synd1_q  <= base1_q;
                        synd3_q  <= base3_q;
                        synd5_q  <= base5_q;
                        tp_idx_q <= '0;
                        valid_q  <= 1'b1;
                        k_q      <= '0;
                        state_q  <= EMIT;
                    end else begin
                        cnt_q <= cnt_q + LRP_W'(1);
                    end
                end
                EMIT: begin
                    if (k_q == LAST_K) begin
                        // Syndrome outputs keep the last pattern's value.
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        k_q      <= k_d;
                        synd1_q  <= synd1_q ^ flip_d.p;
                        synd3_q  <= synd3_q ^ flip_d.p3;
                        synd5_q  <= synd5_q ^ flip_d.p5;
                        tp_idx_q <= tp_idx_q ^ (NUM_LRP'(1) << b_d);
                        last_q   <= (k_d == LAST_K);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_synd1     = synd1_q;
    assign out_synd3     = synd3_q;
    assign out_synd5     = synd5_q;
    assign out_valid     = valid_q;
    assign out_tp_idx    = tp_idx_q;
    assign out_sh_en     = valid_q;
    assign out_pass_last = last_q;
    assign out_busy      = busy_q;

endmodule

// File: tb/tb_tp_synd_gen_t3_seq.sv
module tb_tp_synd_gen_t3_seq;

    logic        clk = 1'b0;
    logic        in_ctr_Srst, in_ctr_en, in_start;
    logic [9:0]  in_synd1, in_synd3, in_synd5;
    logic [29:0] in_loc;
    logic [9:0]  out_synd1, out_synd3, out_synd5;
    logic        out_valid, out_sh_en, out_pass_last, out_busy;
    logic [2:0]  out_tp_idx;

    tp_synd_gen_t3_seq #(.GF_LEN(10), .NUM_LRP(3), .TEST_PATTEN_NUMS(8)) dut (
        .clk(clk), .in_ctr_Srst(in_ctr_Srst), .in_ctr_en(in_ctr_en),
        .in_start(in_start), .in_synd1(in_synd1), .in_synd3(in_synd3),
        .in_synd5(in_synd5), .in_loc(in_loc), .out_synd1(out_synd1),
        .out_synd3(out_synd3), .out_synd5(out_synd5), .out_valid(out_valid),
        .out_tp_idx(out_tp_idx), .out_sh_en(out_sh_en),
        .out_pass_last(out_pass_last), .out_busy(out_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] s1, s3, s5;
        logic [2:0] idx;
        logic       last;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    // Hand-computed run for locators {1, alpha, alpha^2} with zero base.
    logic [2:0] g_idx [8] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
    logic [9:0] g_s1  [8] = '{10'd0, 10'd1, 10'd3, 10'd2, 10'd6, 10'd7, 10'd5, 10'd4};
    logic [9:0] g_s3  [8] = '{10'd0, 10'd1, 10'd9, 10'd8, 10'd72, 10'd73, 10'd65, 10'd64};
    logic [9:0] g_s5  [8] = '{10'd0, 10'd1, 10'd33, 10'd32, 10'd41, 10'd40, 10'd8, 10'd9};

    localparam logic [29:0] LOCS = {10'd4, 10'd2, 10'd1};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: the consumer takes one triple per enabled cycle with valid high.
    always @(negedge clk) begin
        if (in_ctr_en === 1'b1 && out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid actual=idx%0d required=none at %0t",
                         out_tp_idx, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("synd1", 32'(out_synd1), 32'(e.s1));
                chk("synd3", 32'(out_synd3), 32'(e.s3));
                chk("synd5", 32'(out_synd5), 32'(e.s5));
                chk("tp_idx", 32'(out_tp_idx), 32'(e.idx));
                chk("pass_last", 32'(out_pass_last), 32'(e.last));
                chk("sh_en", 32'(out_sh_en), 32'd1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_run(input logic [9:0] b1, input logic [9:0] b3,
                            input logic [9:0] b5, input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.s1   = b1 ^ g_s1[i];
            e.s3   = b3 ^ g_s3[i];
            e.s5   = b5 ^ g_s5[i];
            e.idx  = g_idx[i];
            e.last = (i == 7);
            sb.push_back(e);
        end
    endtask

    task automatic start_run(input logic [9:0] b1, input logic [9:0] b3,
                             input logic [9:0] b5);
        in_synd1 = b1;
        in_synd3 = b3;
        in_synd5 = b5;
        in_loc   = LOCS;
        in_start = 1'b1;
        tick();
        in_start = 1'b0;
    endtask

    // Valid rises on the third edge after the start edge (fourth counting it).
    task automatic check_latency();
        int n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("latency", 32'(n), 32'd3);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (out_busy !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        chk("idle_timeout", 32'(n < 100), 32'd1);
    endtask

    task automatic wait_idx(input logic [2:0] idx);
        int n = 0;
        while (!(out_valid === 1'b1 && out_tp_idx == idx) && n < 50) begin
            tick();
            n++;
        end
        chk("wait_idx_timeout", 32'(n < 50), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        in_ctr_Srst = 1'b1;
        in_ctr_en   = 1'b1;
        in_start    = 1'b0;
        in_synd1    = '0;
        in_synd3    = '0;
        in_synd5    = '0;
        in_loc      = '0;
        tick();
        tick();
        in_ctr_Srst = 1'b0;

        // Reset state
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(out_busy), 32'd0);
        chk("rst_last", 32'(out_pass_last), 32'd0);
        chk("rst_s1", 32'(out_synd1), 32'd0);
        chk("rst_idx", 32'(out_tp_idx), 32'd0);
        tick();

        // Basic Gray run
        push_run(10'h000, 10'h000, 10'h000, 8);
        start_run(10'h000, 10'h000, 10'h000);
        chk("busy_after_start", 32'(out_busy), 32'd1);
        check_latency();
        wait_idle();
        chk("basic_drain", 32'(sb.size()), 32'd0);
        chk("hold_s1", 32'(out_synd1), 32'd4);
        chk("hold_s3", 32'(out_synd3), 32'd64);
        chk("hold_s5", 32'(out_synd5), 32'd9);
        chk("end_valid", 32'(out_valid), 32'd0);
        chk("end_last", 32'(out_pass_last), 32'd0);
        tick();
        tick();

        // Base offset run
        push_run(10'h155, 10'h2AA, 10'h0F0, 8);
        start_run(10'h155, 10'h2AA, 10'h0F0);
        check_latency();
        wait_idle();
        chk("offset_drain", 32'(sb.size()), 32'd0);
        tick();

        // Enable stall during PREP and at EMIT k=3
        push_run(10'h000, 10'h000, 10'h000, 8);
        start_run(10'h000, 10'h000, 10'h000);
        tick();
        in_ctr_en = 1'b0;
        tick();
        tick();
        tick();
        chk("stall_prep_valid", 32'(out_valid), 32'd0);
        chk("stall_prep_busy", 32'(out_busy), 32'd1);
        in_ctr_en = 1'b1;
        wait_idx(3'd2);
        in_ctr_en = 1'b0;
        tick();
        tick();
        chk("stall_emit_idx", 32'(out_tp_idx), 32'd2);
        chk("stall_emit_s1", 32'(out_synd1), 32'd2);
        chk("stall_emit_s3", 32'(out_synd3), 32'd8);
        chk("stall_emit_s5", 32'(out_synd5), 32'd32);
        chk("stall_emit_valid", 32'(out_valid), 32'd1);
        in_ctr_en = 1'b1;
        wait_idle();
        chk("stall_drain", 32'(sb.size()), 32'd0);
        tick();

        // Start while busy at EMIT k=2 is ignored
        push_run(10'h0A5, 10'h35A, 10'h001, 8);
        start_run(10'h0A5, 10'h35A, 10'h001);
        wait_idx(3'd3);
        in_synd1 = 10'h3FF;
        in_synd3 = 10'h3FF;
        in_synd5 = 10'h3FF;
        in_loc   = {10'd7, 10'd7, 10'd7};
        in_start = 1'b1;
        tick();
        in_start = 1'b0;
        chk("busy_start_busy", 32'(out_busy), 32'd1);
        wait_idle();

        // Back-to-back: start on the cycle after valid falls
        push_run(10'h3FF, 10'h001, 10'h200, 8);
        start_run(10'h3FF, 10'h001, 10'h200);
        chk("b2b_accepted", 32'(out_busy), 32'd1);
        check_latency();
        wait_idle();
        chk("b2b_drain", 32'(sb.size()), 32'd0);
        tick();

        // Reset mid-run at EMIT k=4 (tp_idx 6)
        push_run(10'h011, 10'h022, 10'h033, 5);
        start_run(10'h011, 10'h022, 10'h033);
        wait_idx(3'd6);
        in_ctr_Srst = 1'b1;
        tick();
        in_ctr_Srst = 1'b0;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(out_busy), 32'd0);
        chk("mid_rst_last", 32'(out_pass_last), 32'd0);
        chk("mid_rst_s1", 32'(out_synd1), 32'd0);
        chk("mid_rst_s3", 32'(out_synd3), 32'd0);
        chk("mid_rst_s5", 32'(out_synd5), 32'd0);
        chk("mid_rst_idx", 32'(out_tp_idx), 32'd0);
        chk("mid_rst_drain", 32'(sb.size()), 32'd0);
        tick();
        tick();
        chk("mid_rst_quiet", 32'(out_valid), 32'd0);

        // Full run after reset
        push_run(10'h000, 10'h000, 10'h000, 8);
        start_run(10'h000, 10'h000, 10'h000);
        check_latency();
        wait_idle();
        tick();
        tick();
        chk("final_drain", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
